rand_stim_gen: RTL

Synthesizable pseudo-random stimulus source for block-level benches on toolchains without verification licenses. On a start pulse it emits `len_i` random words in the range [MIN_VAL, MAX_VAL] over a valid/ready stream, with a random 1..GAP_MAX+1 cycle idle gap before each word. It sits directly upstream of the DUT input port. The LFSR-based randomization matches the behavioural package model bit for bit, so expected data can be predicted in the bench.

---
 rtl/rand_stim_pkg.sv | 24 ++
 rtl/lfsr32_xnor.sv | 34 +++
 rtl/rand_stim_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rand_stim_pkg.sv
// Shared types, constants and the LFSR step function for rand_stim_gen.
// The step function is the single source of the XNOR-LFSR sequence.
package rand_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hAE1F_B42C;

  // Zero-based bit positions for XNOR taps 32, 22, 2, 1.
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~^{s[TAP_A], s[TAP_B], s[TAP_C], s[TAP_D]}};
  endfunction

endpackage

// File: rtl/lfsr32_xnor.sv
// 32-bit XNOR Fibonacci LFSR; advances one step when step_i is high.
// The all-ones state is the lock-up state and must never be used as SEED.
module lfsr32_xnor
  import rand_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rand_stim_gen.sv
// Pseudo-random valid/ready word source with random idle gaps before each word.
// Define RAND_STIM_LOG_EN to compile a simulation-only handshake/done logger.
module rand_stim_gen
  import rand_stim_pkg::*;
#(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       MIN_VAL = 0,
  parameter int unsigned       MAX_VAL = 255,
  parameter int unsigned       GAP_MAX = 3,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [15:0]      len_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      count_o
);

  localparam int unsigned GAP_W = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [31:0] GAP_MOD = 32'(GAP_MAX + 1);
  localparam logic [31:0] SPAN = 32'(MAX_VAL - MIN_VAL + 1);
  localparam logic [31:0] MIN_W = 32'(MIN_VAL);

  if (SEED == 32'hFFFF_FFFF) begin : gSeedCheck
    $error("rand_stim_gen: SEED 32'hFFFFFFFF locks up the XNOR LFSR");
  end
  if ((MIN_VAL > MAX_VAL) || ((64'(MAX_VAL) >> WIDTH) != 64'd0)) begin : gRangeCheck
    $error("rand_stim_gen: need MIN_VAL <= MAX_VAL < 2**WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       len_q, len_d;
  logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;

  logic              lfsrStep;
  logic [LFSR_W-1:0] lfsrState;
  logic [LFSR_W-1:0] draw;
  logic [GAP_W-1:0]  gapDraw;
  logic [WIDTH-1:0]  dataDraw;
  logic              handshake;
  logic              lastWord;

  lfsr32_xnor #(
    .SEED(SEED)
  ) uLfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (lfsrStep),
    .state_o(lfsrState)
  );

  // A draw uses the post-step value; the LFSR only commits it when lfsrStep is set.
  assign draw      = lfsr_next(lfsrState);
  assign gapDraw   = GAP_W'(draw % GAP_MOD);
  assign dataDraw  = WIDTH'(MIN_W + (draw % SPAN));
  assign handshake = valid_q && ready_i;
  assign lastWord  = (count_q + 16'd1) == len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      len_q    <= '0;
      gapCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      count_q  <= count_d;
      len_q    <= len_d;
      gapCnt_q <= gapCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (len_i != 16'd0)) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == '0) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          state_d = lastWord ? ST_IDLE : ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only one arm can step the LFSR in a cycle, which keeps the draw sequence deterministic.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    count_d  = count_q;
    len_d    = len_q;
    gapCnt_d = gapCnt_q;
    lfsrStep = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != 16'd0) begin
            len_d    = len_i;
            count_d  = '0;
            gapCnt_d = gapDraw;
            lfsrStep = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gapCnt_q != '0) begin
          gapCnt_d = gapCnt_q - GAP_W'(1);
        end else begin
          data_d   = dataDraw;
          valid_d  = 1'b1;
          lfsrStep = 1'b1;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          count_d = count_q + 16'd1;
          valid_d = 1'b0;
          if (lastWord) begin
            done_d = 1'b1;
          end else begin
            gapCnt_d = gapDraw;
            lfsrStep = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != ST_IDLE);

`ifdef RAND_STIM_LOG_EN
  always @(posedge clk) begin
    if (!rst && handshake) begin
      $display("[%0t] [RAND_STIM] word %0d = %0d", $time, count_q + 16'd1, data_q);
    end
    if (!rst && done_q) begin
      $display("[%0t] [RAND_STIM] done", $time);
    end
  end
`endif

endmodule
